// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side: drives operands and accepts results
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - chunked carry-pipelined adder/subtractor with valid/ready flow control
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_adder_if.slave  bus
);
  localparam int CHUNK = WIDTH / STAGES;

  // Per-stage registers: full operands travel along so later stages can add
  // their chunk; partial sum holds the chunks already added; carry links stages.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_d;

  logic             v_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] s_in;
  logic             c_in;
  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] s_tmp;
  int               p;

  logic advance;

  // The whole pipe moves as one; the only stall source is a held output
  assign advance      = !vld_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  // Next value of every stage: add this stage's chunk onto what arrives from the stage before
  always_comb begin
    ovf_d = 1'b0;
    v_in  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    s_in  = '0;
    c_in  = 1'b0;
    part  = '0;
    s_tmp = '0;
    p     = 0;
    for (int k = 0; k < STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        // Subtract is a + ~b + 1, so the inverted operand and forced carry enter here
        v_in = bus.in_valid;
        a_in = bus.a;
        b_in = bus.sub ? ~bus.b : bus.b;
        s_in = '0;
        c_in = bus.sub | bus.cin;
      end else begin
        v_in = vld_q[p];
        a_in = a_q[p];
        b_in = b_q[p];
        s_in = s_q[p];
        c_in = c_q[p];
      end
      part  = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_in};
      s_tmp = s_in;
      s_tmp[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      vld_d[k] = v_in;
      a_d[k]   = a_in;
      b_d[k]   = b_in;
      s_d[k]   = s_tmp;
      c_d[k]   = part[CHUNK];
      if (k == STAGES - 1) begin
        ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_tmp[WIDTH-1] != a_in[WIDTH-1]);
      end
    end
  end

  // Stage registers: reset clears everything in flight, otherwise shift only on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder against an arithmetic model
module tb_pipe_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          t;
  } exp_t;

  logic clk;
  logic rst;
  pipe_adder_if #(.WIDTH(WIDTH)) ifc ();

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          tick_n = 0;
  int          last_stall = -1000;
  int          n_pop = 0;
  bit          held_valid = 0;
  logic [31:0] held_sum;
  logic        held_cout;
  logic        held_ovf;
  bit          last_ov;
  bit          last_in_ready;
  bit          use_fixed = 0;
  exp_t        fixed_exp;
  exp_t        exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [32:0] full;
    longint      sr;
    if (sub) begin
      full = 33'(a) + 33'h1_0000_0000 - 33'(b);
      sr   = longint'($signed(a)) - longint'($signed(b));
    end else begin
      full = 33'(a) + 33'(b) + 33'(cin);
      sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.t    = 0;
    return e;
  endfunction

  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    acc           = 0;
    last_ov       = ifc.out_valid;
    last_in_ready = ifc.in_ready;
    chk("in_ready_rule", ifc.in_ready, !ifc.out_valid || ifc.out_ready);
    if (held_valid) begin
      chk("hold_valid", ifc.out_valid, 1);
      chk("hold_sum", ifc.sum, held_sum);
      chk("hold_cout", ifc.cout, held_cout);
      chk("hold_ovf", ifc.ovf, held_ovf);
    end
    if (ifc.out_valid && ifc.out_ready) begin
      n_pop++;
      chk("unexpected_out", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sum", ifc.sum, e.sum);
        chk("cout", ifc.cout, e.cout);
        chk("ovf", ifc.ovf, e.ovf);
        if (e.t > last_stall) chk("latency", tick_n - e.t, STAGES);
      end
    end
    held_valid = ifc.out_valid && !ifc.out_ready && !rst;
    held_sum   = ifc.sum;
    held_cout  = ifc.cout;
    held_ovf   = ifc.ovf;
    if (!ifc.out_ready) last_stall = tick_n;
    if (rst) begin
      exp_q.delete();
    end else if (ifc.in_valid && ifc.in_ready) begin
      e   = use_fixed ? fixed_exp : model(ifc.a, ifc.b, ifc.cin, ifc.sub);
      e.t = tick_n;
      exp_q.push_back(e);
      acc = 1;
    end
    tick_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    ifc.in_valid  = 0;
    ifc.out_ready = 1;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || ifc.out_valid); i++) tick(acc);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_rand();
    ifc.a   = $urandom;
    ifc.b   = $urandom;
    ifc.cin = 1'($urandom);
    ifc.sub = 1'($urandom);
  endtask

  task automatic send_fixed(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, input logic [31:0] esum, input logic ecout,
                            input logic eovf);
    bit acc;
    ifc.a = a; ifc.b = b; ifc.cin = cin; ifc.sub = sub;
    ifc.in_valid   = 1;
    use_fixed      = 1;
    fixed_exp.sum  = esum;
    fixed_exp.cout = ecout;
    fixed_exp.ovf  = eovf;
    fixed_exp.t    = 0;
    tick(acc);
    chk("fixed_accept", acc, 1);
    use_fixed    = 0;
    ifc.in_valid = 0;
    drain();
  endtask

  logic [31:0] ra [8];
  logic [31:0] rb [8];
  logic        rc [8];
  logic        rs [8];
  bit          inv [20];
  bit          ov  [20];

  initial begin
    bit acc;
    int idx;
    int pops0;

    rst = 1;
    ifc.in_valid = 0; ifc.a = 0; ifc.b = 0; ifc.cin = 0; ifc.sub = 0;
    ifc.out_ready = 1;
    tick(acc);
    tick(acc);
    rst = 0;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_sum", ifc.sum, 0);
    chk("rst_cout", ifc.cout, 0);
    chk("rst_ovf", ifc.ovf, 0);

    send_fixed(32'hFFC00FFC, 32'hFFFFF003, 0, 0, 32'hFFBFFFFF, 1, 0);
    send_fixed(32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0);
    send_fixed(32'h7FFFFFFF, 32'hFFFFFFFF, 0, 1, 32'h80000000, 0, 1);
    send_fixed(32'd5, 32'd3, 1, 1, 32'd2, 1, 0);

    // Back-to-back random operations with a 3-cycle downstream stall
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom); rs[i] = 1'($urandom);
    end
    pops0 = n_pop;
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      ifc.out_ready = !(c >= 5 && c <= 7);
      if (idx < 8) begin
        ifc.in_valid = 1;
        ifc.a = ra[idx]; ifc.b = rb[idx]; ifc.cin = rc[idx]; ifc.sub = rs[idx];
      end else begin
        ifc.in_valid = 0;
      end
      tick(acc);
      if (acc) idx++;
      if (c >= 5 && c <= 7) chk("stall_in_ready", last_in_ready, 0);
    end
    drain();
    chk("stall_all_issued", idx, 8);
    chk("stall_result_count", n_pop - pops0, 8);

    // Reset with three operations in flight, plus an operand offered during reset
    for (int i = 0; i < 3; i++) begin
      ifc.in_valid = 1;
      set_rand();
      tick(acc);
    end
    rst = 1;
    set_rand();
    tick(acc);
    rst = 0;
    ifc.in_valid = 0;
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_in_ready", ifc.in_ready, 1);
    pops0 = n_pop;
    for (int i = 0; i < 8; i++) tick(acc);
    chk("midrst_no_stale", n_pop - pops0, 0);

    // Alternating valid: bubbles must survive the pipe unchanged
    drain();
    for (int t = 0; t < 20; t++) begin
      ifc.in_valid = (t < 16) && (t % 2 == 0);
      set_rand();
      inv[t] = ifc.in_valid;
      tick(acc);
      ov[t] = last_ov;
    end
    for (int t = 0; t < 16; t++) chk("bubble_pattern", ov[t+4], inv[t]);

    // Random traffic with random backpressure
    for (int t = 0; t < 80; t++) begin
      ifc.in_valid  = 1'($urandom);
      ifc.out_ready = ($urandom % 4) != 0;
      set_rand();
      tick(acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
